// File: rtl/serial_pattern_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_pattern_detector                                      |
// | Description : Serial bit-stream matcher with one-cycle match pulse and     |
// |               saturating match counter.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_pattern_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             en,
  input  logic             clr,
  output logic             det,
  output logic [CNT_W-1:0] det_count,
  output logic             primed
);

  localparam int                FILL_W      = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] c_fill_prim = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] r_shreg;
  logic [FILL_W-1:0]  r_fill;
  logic               r_det;
  logic [CNT_W-1:0]   r_det_count;

  logic [PAT_LEN-1:0] w_nxt;
  logic               w_primed;
  logic               w_match;
  logic               w_cnt_sat;

  assign w_nxt     = {r_shreg[PAT_LEN-2:0], d};
  assign w_primed  = (r_fill >= c_fill_prim);
  // A full history is required so a partially filled register can never match.
  assign w_match   = (w_nxt == PATTERN) && w_primed;
  assign w_cnt_sat = &r_det_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_fill      <= '0;
      r_det       <= 1'b0;
      r_det_count <= '0;
    end else if (clr) begin
      r_shreg     <= '0;
      r_fill      <= '0;
      r_det       <= 1'b0;
      r_det_count <= '0;
    end else if (en) begin
      r_det <= w_match;
      if (w_match && !w_cnt_sat) begin
        r_det_count <= r_det_count + 1'b1;
      end
      if (w_match && !OVERLAP) begin
        r_shreg <= '0;
        r_fill  <= '0;
      end else begin
        r_shreg <= w_nxt;
        if (r_fill != c_fill_full) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end else begin
      r_det <= 1'b0;
    end
  end

  assign det       = r_det;
  assign det_count = r_det_count;
  assign primed    = w_primed;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_pattern_detector                                   |
// | Description : Directed self-checking bench for serial_pattern_detector.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_serial_pattern_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d   = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;

  logic       ov_det,   nov_det,   c2_det,   z_det;
  logic [7:0] ov_cnt,   nov_cnt,   z_cnt;
  logic [1:0] c2_cnt;
  logic       ov_prim,  nov_prim,  c2_prim,  z_prim;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
    .det(ov_det), .det_count(ov_cnt), .primed(ov_prim));

  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
    .det(nov_det), .det_count(nov_cnt), .primed(nov_prim));

  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
    .det(c2_det), .det_count(c2_cnt), .primed(c2_prim));

  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) u_zero (
    .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
    .det(z_det), .det_count(z_cnt), .primed(z_prim));

  // Drive one bit on the falling edge, let the rising edge take it, return 1ns later.
  task automatic push(input logic b, input logic e);
    @(negedge clk);
    d  = b;
    en = e;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    en  = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++;
    if ({ov_det, nov_det, c2_det, z_det} !== 4'b0000) $display("FAIL reset_det got=%b exp=0000", {ov_det, nov_det, c2_det, z_det});
    else n_pass++;
    n_total++;
    if (ov_cnt !== 8'd0 || c2_cnt !== 2'd0) $display("FAIL reset_count got=%0d/%0d exp=0/0", ov_cnt, c2_cnt);
    else n_pass++;
    n_total++;
    if ({ov_prim, z_prim} !== 2'b00) $display("FAIL reset_primed got=%b exp=00", {ov_prim, z_prim});
    else n_pass++;
  endtask

  task automatic test_overlap_modes();
    logic [6:0] bits;
    logic [6:0] exp_ov;
    logic [6:0] exp_nov;
    logic [6:0] exp_prim;
    bits     = 7'b1011011;
    exp_ov   = 7'b0001001;
    exp_nov  = 7'b0001000;
    exp_prim = 7'b0011111;
    apply_reset();
    for (int i = 6; i >= 0; i--) begin
      push(bits[i], 1'b1);
      n_total++;
      if (ov_det !== exp_ov[i]) $display("FAIL ov_det bit%0d got=%b exp=%b", 7 - i, ov_det, exp_ov[i]);
      else n_pass++;
      n_total++;
      if (nov_det !== exp_nov[i]) $display("FAIL nov_det bit%0d got=%b exp=%b", 7 - i, nov_det, exp_nov[i]);
      else n_pass++;
      n_total++;
      if (ov_prim !== exp_prim[i]) $display("FAIL ov_primed bit%0d got=%b exp=%b", 7 - i, ov_prim, exp_prim[i]);
      else n_pass++;
    end
    n_total++;
    if (ov_cnt !== 8'd2) $display("FAIL ov_count got=%0d exp=2", ov_cnt);
    else n_pass++;
    n_total++;
    if (nov_cnt !== 8'd1) $display("FAIL nov_count got=%0d exp=1", nov_cnt);
    else n_pass++;
    n_total++;
    if (nov_prim !== 1'b1) $display("FAIL nov_primed_after got=%b exp=1", nov_prim);
    else n_pass++;
  endtask

  task automatic test_enable_gap();
    apply_reset();
    push(1'b1, 1'b1);
    push(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push(i[0] ? 1'b0 : 1'b1, 1'b0);
      n_total++;
      if (ov_det !== 1'b0) $display("FAIL gap_det idle%0d got=%b exp=0", i, ov_det);
      else n_pass++;
    end
    n_total++;
    if (ov_prim !== 1'b0) $display("FAIL gap_primed got=%b exp=0", ov_prim);
    else n_pass++;
    push(1'b1, 1'b1);
    n_total++;
    if (ov_det !== 1'b0) $display("FAIL gap_det bit3 got=%b exp=0", ov_det);
    else n_pass++;
    push(1'b1, 1'b1);
    n_total++;
    if (ov_det !== 1'b1) $display("FAIL gap_det bit4 got=%b exp=1", ov_det);
    else n_pass++;
    push(1'b1, 1'b0);
    n_total++;
    if (ov_det !== 1'b0) $display("FAIL gap_det_pulse_end got=%b exp=0", ov_det);
    else n_pass++;
    n_total++;
    if (ov_cnt !== 8'd1) $display("FAIL gap_count got=%0d exp=1", ov_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back_saturate();
    logic [15:0] bits;
    logic [15:0] exp_det;
    bits    = 16'b1011011011011011;
    exp_det = 16'b0001001001001001;
    apply_reset();
    for (int i = 15; i >= 0; i--) begin
      push(bits[i], 1'b1);
      n_total++;
      if (c2_det !== exp_det[i]) $display("FAIL sat_det bit%0d got=%b exp=%b", 16 - i, c2_det, exp_det[i]);
      else n_pass++;
    end
    n_total++;
    if (c2_cnt !== 2'd3) $display("FAIL sat_count got=%0d exp=3", c2_cnt);
    else n_pass++;
    n_total++;
    if (ov_cnt !== 8'd5) $display("FAIL wide_count got=%0d exp=5", ov_cnt);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    // History continues from the previous stream; count is nonzero going in.
    push(1'b1, 1'b1);
    push(1'b0, 1'b1);
    push(1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (ov_cnt !== 8'd0) $display("FAIL arst_count_now got=%0d exp=0", ov_cnt);
    else n_pass++;
    n_total++;
    if (ov_prim !== 1'b0) $display("FAIL arst_primed_now got=%b exp=0", ov_prim);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    push(1'b1, 1'b1);
    n_total++;
    if (ov_det !== 1'b0) $display("FAIL arst_det got=%b exp=0", ov_det);
    else n_pass++;
    n_total++;
    if (ov_cnt !== 8'd0) $display("FAIL arst_count got=%0d exp=0", ov_cnt);
    else n_pass++;
    n_total++;
    if (ov_prim !== 1'b0) $display("FAIL arst_primed got=%b exp=0", ov_prim);
    else n_pass++;
  endtask

  task automatic test_clear_priority();
    apply_reset();
    push(1'b1, 1'b1);
    push(1'b0, 1'b1);
    push(1'b1, 1'b1);
    push(1'b1, 1'b1);
    push(1'b0, 1'b1);
    push(1'b1, 1'b1);
    n_total++;
    if (ov_cnt !== 8'd1) $display("FAIL clr_pre_count got=%0d exp=1", ov_cnt);
    else n_pass++;
    // This bit would complete 1011 if clr did not win.
    @(negedge clk);
    d   = 1'b1;
    en  = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
    n_total++;
    if (ov_det !== 1'b0) $display("FAIL clr_det got=%b exp=0", ov_det);
    else n_pass++;
    n_total++;
    if (ov_cnt !== 8'd0) $display("FAIL clr_count got=%0d exp=0", ov_cnt);
    else n_pass++;
    n_total++;
    if (ov_prim !== 1'b0) $display("FAIL clr_primed got=%b exp=0", ov_prim);
    else n_pass++;
    push(1'b1, 1'b1);
    n_total++;
    if (ov_prim !== 1'b0) $display("FAIL clr_fill_restart got=%b exp=0", ov_prim);
    else n_pass++;
  endtask

  task automatic test_zero_pattern();
    logic [3:0] exp_det;
    exp_det = 4'b0001;
    apply_reset();
    for (int i = 3; i >= 0; i--) begin
      push(1'b0, 1'b1);
      n_total++;
      if (z_det !== exp_det[i]) $display("FAIL zero_det bit%0d got=%b exp=%b", 4 - i, z_det, exp_det[i]);
      else n_pass++;
    end
    n_total++;
    if (z_cnt !== 8'd1) $display("FAIL zero_count got=%0d exp=1", z_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_overlap_modes();
    test_enable_gap();
    test_back_to_back_saturate();
    test_async_reset();
    test_clear_priority();
    test_zero_pattern();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
